// File: rtl/bcd_display_mux.sv
// bcd_display_mux: latches a packed BCD word on the rising edge of the converter's
// done flag and drives its digits one at a time onto a common-anode 7-segment bus
// (active-low segments, active-low one-hot digit enables). Leading zeros can be
// blanked, and a nibble above 9 is shown as a dash.
//
// Capture handshake: the converter's 'pronto' is a level, not a valid/ready pair.
// A word is taken from 'bcd' on every clock edge where pronto is high and was low
// on the previous edge. There is no back-pressure, so the converter must hold
// 'bcd' stable on that edge. 'atualizado' is high for the single cycle after each
// capture. A pronto that stays high captures only once, and it must drop for at
// least one cycle before the next capture.
module bcd_display_mux #(
  parameter int N   = 24,
  parameter int DIV = 50000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           pronto,
  input  logic [N-1:0]   bcd,
  input  logic           blank_zeros,
  output logic [6:0]     seg,
  output logic [N/4-1:0] an,
  output logic           atualizado
);

  localparam int D     = N / 4;
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam int PRE_W = $clog2(DIV);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  // Segment patterns, {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Capture path
  logic           pronto_d_q;
  logic           capture;
  logic [N-1:0]   rdisp_q, rdisp_d;
  logic           atualizado_q, atualizado_d;

  // Scan path
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             scan_step;

  // Digit selection and decode
  logic [D-1:0]   zero_from;   // zero_from[i]: nibbles i..D-1 of rdisp_q are all zero
  logic           zero_run;
  logic [3:0]     cur_nib;
  logic           blank_cur;

  // Registered display outputs
  logic [6:0]     seg_q, seg_d;
  logic [D-1:0]   an_q, an_d;

  // Decode one BCD nibble to its active-low segment pattern; 10..15 become a dash.
  function automatic logic [6:0] decode_nib(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Rising-edge detect on pronto selects a new display word.
  always_comb begin
    capture      = pronto & ~pronto_d_q;
    rdisp_d      = capture ? bcd : rdisp_q;
    atualizado_d = capture;
  end

  // Prescaler wraps at DIV-1; that same cycle moves the scan to the next digit.
  always_comb begin
    scan_step = (presc_q == PRE_LAST);
    presc_d   = scan_step ? '0 : presc_q + PRE_W'(1);
    idx_d     = idx_q;
    if (scan_step) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Mark, for each digit, whether it and every more significant digit are zero.
  // A dash nibble (>9) is nonzero, so it stops the run of leading zeros.
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = D - 1; i >= 0; i--) begin
      zero_run     = zero_run & (rdisp_q[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end

  // Select the nibble under the scan index and decide whether to blank it.
  // Digit 0 is never blanked, so a zero word still shows a single 0.
  always_comb begin
    cur_nib   = '0;
    blank_cur = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = rdisp_q[4*i +: 4];
        blank_cur = blank_zeros & (i != 0) & zero_from[i];
      end
    end
  end

  // Next segment and digit-enable values; the enable stays on for a blanked digit.
  always_comb begin
    seg_d = blank_cur ? SEG_BLANK : decode_nib(cur_nib);
    an_d  = '1;
    for (int k = 0; k < D; k++) begin
      if (idx_q == IDX_W'(k)) begin
        an_d[k] = 1'b0;
      end
    end
  end

  // State and output registers; reset blanks the display and forgets the word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pronto_d_q   <= 1'b0;
      rdisp_q      <= '0;
      atualizado_q <= 1'b0;
      presc_q      <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
    end else begin
      pronto_d_q   <= pronto;
      rdisp_q      <= rdisp_d;
      atualizado_q <= atualizado_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign atualizado = atualizado_q;

endmodule
